seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter N, default 3, meaning pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter CW, default 8, meaning match-counter width in bits.
REQ-003 SHALL have parameter RST_PATTERN, default 3'b101 (N bits), meaning the pattern in force after reset.
REQ-004 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: x  input  1  serial data bit, sampled when en=1.
REQ-007 SHALL have port: en  input  1  x-valid qualifier; en=0 freezes all state.
REQ-008 SHALL have port: mode  input  1  0 = non-overlapping detection, 1 = overlapping detection.
REQ-009 SHALL have port: load  input  1  single-cycle strobe that latches pattern_in.
REQ-010 SHALL have port: pattern_in  input  N  new pattern; the oldest bit is the MSB.
REQ-011 SHALL have port: z  output  1  Mealy match flag, combinational from state and the current x/en/load.
REQ-012 SHALL have port: match_cnt  output  CW  saturating count of matches (only present under SEQ_DET_CNT_EN).

Function
REQ-013 SHALL hold pat_q (N bits), hist_q (N-1 bits, newest bit at LSB) and fill_q (0..N-1, count of valid history bits).
REQ-014 SHALL form window = {hist_q, x}, and SHALL define match = en & ~load & (fill_q == N-1) & (window == pat_q).
REQ-015 SHALL drive z = match in the same cycle as the final pattern bit, with zero latency.
REQ-016 SHALL, when en=1 and load=0 and there is no match, shift x into hist_q and set fill_q <= min(fill_q+1, N-1).
REQ-017 SHALL, on a match in overlapping mode (mode=1), shift x into hist_q and keep fill_q = N-1, so the suffix can begin the next match.
REQ-018 SHALL, on a match in non-overlapping mode (mode=0), clear hist_q and fill_q to 0, so the next match needs N fresh bits.
REQ-019 SHALL, when load=1, set pat_q <= pattern_in, clear hist_q and fill_q, discard that cycle's x, and force z=0; load SHALL take priority over en.
REQ-020 SHALL, when en=0 and load=0, leave all registers unchanged and drive z=0.
REQ-021 SHALL allow mode to change on any cycle, taking effect on the current cycle's match handling, with no flush.
REQ-022 SHALL make all-zero and all-one patterns legal; in overlapping mode a run of identical bits SHALL match on every bit after the first N-1.

Reset
REQ-023 SHALL, when reset=1 at a rising edge of clk, set pat_q=RST_PATTERN, hist_q=0, fill_q=0 and match_cnt=0, overriding load and en.
REQ-024 SHALL drive z=0 while reset is asserted, and SHALL make the first bit that can count toward a match the one sampled on the first enabled cycle after reset deasserts.
REQ-025 SHALL abandon any partial match when reset is asserted mid-sequence, with no match reported later from pre-reset bits.

Configuration
REQ-026 SHALL, with macro SEQ_DET_CNT_EN defined, include match_cnt, which increments by 1 on each cycle with z=1, saturates at 2^CW-1, and is cleared by reset or load.
REQ-027 SHALL, without SEQ_DET_CNT_EN, omit the match_cnt port and its register entirely, leaving all other behaviour identical.

Structure
REQ-028 SHALL place in shared package seq_det_pkg: the mode encodings (MODE_NONOVL=1'b0, MODE_OVL=1'b1) and a fill-counter width function of clog2(N).
REQ-029 SHALL implement the saturating counter as sub-module sat_counter (parameter CW; inputs clk, reset, clr, inc; output cnt), instantiated only under SEQ_DET_CNT_EN.
REQ-030 SHALL keep the history/fill logic and match comparison in seq_detect_param itself, with no further sub-modules.

Verification
REQ-031 SHALL cover: N=3, reset pattern 101, mode=0, en=1, x=1,0,1,0,1 -> z=1 on bit 3 only; match_cnt=1.
REQ-032 SHALL cover: same stream with mode=1 -> z=1 on bits 3 and 5; match_cnt=2.
REQ-033 SHALL cover: load with pattern_in=110, then x=1,1,0,1,1,0 in mode=0 -> z=1 on bits 3 and 6; the x presented on the load cycle is ignored.
REQ-034 SHALL cover: x=1,0 with en=0 for 4 cycles, then en=1 with x=1 -> z=1 on that cycle, and z=0 throughout the en=0 gap.
REQ-035 SHALL cover: x=1,0, then reset pulsed for 1 cycle, then x=1 -> z=0; then x=0,1 -> z=1 on the final 1.
REQ-036 SHALL cover: CW=2, mode=1, pattern 111, x=1 held for 8 cycles -> z=1 on cycles 3..8; match_cnt saturates at 3.

Source files
------------

// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module : seq_det_pkg
// Brief  : Shared definitions for the parameterised serial sequence detector:
//          detection-mode encodings and the fill-counter width helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

  // Detection mode, driven on the 'mode' input of seq_detect_param.
  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } det_mode_e;

  // Width of a counter that must hold 0..n-1 valid history bits.
  function automatic int fill_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : seq_det_pkg

`default_nettype wire

// File: rtl/seq_detect_param_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at its maximum value (2^CW-1).
// Ports  : clk    - clock, rising edge
//          reset  - synchronous active-high reset, clears the count
//          clr    - synchronous clear, takes priority over inc
//          inc    - increment request
//          cnt    - current count (CW bits)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != C_CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/seq_detect_param.sv
// ============================================================================
// Module : seq_detect_param
// Brief  : Serial pattern detector with runtime-loadable N-bit pattern and
//          selectable overlapping / non-overlapping detection. Mealy output.
// Ports  : clk        - clock, rising edge
//          reset      - synchronous active-high reset
//          x          - serial data bit, sampled when en=1
//          en         - x-valid qualifier; en=0 freezes all state
//          mode       - 0 non-overlapping, 1 overlapping
//          load       - strobe latching pattern_in (priority over en)
//          pattern_in - new pattern, oldest bit at MSB
//          z          - match flag, same cycle as the final pattern bit
//          match_cnt  - saturating match count (only with SEQ_DET_CNT_EN)
// Config : define SEQ_DET_CNT_EN to include match_cnt and its counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int           N           = 3,
  parameter int           CW          = 8,
  parameter logic [N-1:0] RST_PATTERN = 3'b101
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         x,
  input  logic         en,
  input  logic         mode,
  input  logic         load,
  input  logic [N-1:0] pattern_in,
  output logic         z
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CW-1:0] match_cnt
`endif
);

  localparam int             FW          = fill_width(N);
  localparam logic [FW-1:0]  C_FILL_FULL = FW'(N - 1);

  logic [N-1:0]  pat_q,  pat_d;
  logic [N-2:0]  hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;

  logic [N-1:0]  window;
  logic          match;

  // The current bit completes the window; history supplies the older N-1.
  assign window = {hist_q, x};
  assign match  = en & ~load & (fill_q == C_FILL_FULL) & (window == pat_q);

  // Gate with reset so nothing is flagged on a cycle whose state is discarded.
  assign z = match & ~reset;

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (load) begin
      pat_d  = pattern_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      if (match && (det_mode_e'(mode) == MODE_NONOVL)) begin
        // Consume the whole match: next detection needs N fresh bits.
        hist_d = '0;
        fill_d = '0;
      end else begin
        // Overlapping matches also shift, so the suffix can start a new match.
        hist_d = window[N-2:0];
        fill_d = (fill_q == C_FILL_FULL) ? C_FILL_FULL : fill_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= RST_PATTERN;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

`ifdef SEQ_DET_CNT_EN
  sat_counter #(
    .CW (CW)
  ) u_sat_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .inc   (z),
    .cnt   (match_cnt)
  );
`endif

endmodule : seq_detect_param

`default_nettype wire

// File: tb/tb_seq_detect_param.sv
// ============================================================================
// Module : tb_seq_detect_param
// Brief  : Directed self-checking bench for seq_detect_param (N=3, CW=2).
//          Expected z values are queued as each step is driven and popped
//          when the DUT output is sampled mid-cycle.
// Config : match_cnt checks are compiled in when SEQ_DET_CNT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_detect_param;

  localparam int N  = 3;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         x = 1'b0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] pattern_in = '0;
  logic         z;
`ifdef SEQ_DET_CNT_EN
  logic [CW-1:0] match_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_detect_param #(
    .N           (N),
    .CW          (CW),
    .RST_PATTERN (3'b101)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .en         (en),
    .mode       (mode),
    .load       (load),
    .pattern_in (pattern_in),
    .z          (z)
`ifdef SEQ_DET_CNT_EN
    ,
    .match_cnt  (match_cnt)
`endif
  );

  // One clock cycle: drive inputs just after an edge, queue the expected z,
  // sample mid-cycle, then advance to just after the next edge.
  task automatic step(input string tag, input logic i_rst, input logic i_load,
                      input logic i_en, input logic i_mode, input logic i_x,
                      input logic [N-1:0] i_pat, input logic exp_z);
    logic e;
    reset      = i_rst;
    load       = i_load;
    en         = i_en;
    mode       = i_mode;
    x          = i_x;
    pattern_in = i_pat;
    exp_q.push_back(exp_z);
    #4;
    e = exp_q.pop_front();
    checks++;
    assert (z === e) else begin
      failures++;
      $error("FAIL %s: z observed=%b expected=%b", tag, z, e);
    end
    @(posedge clk);
    #1;
  endtask

  // Serial stream in fixed mode with en=1; bits and expected z given MSB-first.
  task automatic stream(input string tag, input logic i_mode, input int len,
                        input logic [15:0] bits, input logic [15:0] exp_z);
    for (int i = len - 1; i >= 0; i--) begin
      step(tag, 1'b0, 1'b0, 1'b1, i_mode, bits[i], 3'b000, exp_z[i]);
    end
  endtask

  task automatic check_cnt(input string tag, input int expected);
`ifdef SEQ_DET_CNT_EN
    checks++;
    assert (match_cnt === CW'(expected)) else begin
      failures++;
      $error("FAIL %s: match_cnt observed=%0d expected=%0d", tag, match_cnt, expected);
    end
`else
    if (tag.len() == 0 && expected < 0) $display("unused");
`endif
  endtask

  initial begin
    // Reset, with an input that would otherwise be acted on.
    @(posedge clk);
    #1;
    step("rst_z", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
    checks++;
    assert (dut.pat_q === 3'b101 && dut.hist_q === 2'b00 && dut.fill_q === '0) else begin
      failures++;
      $error("FAIL rst_state: pat/hist/fill observed=%b/%b/%0d expected=101/00/0",
             dut.pat_q, dut.hist_q, dut.fill_q);
    end
    check_cnt("rst_cnt", 0);

    // Non-overlapping 10101 with pattern 101: only bit 3 matches.
    stream("nonovl", 1'b0, 5, 16'b10101, 16'b00100);
    check_cnt("nonovl_cnt", 1);

    // Same stream overlapping: bits 3 and 5.
    step("rst2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    stream("ovl", 1'b1, 5, 16'b10101, 16'b00101);
    check_cnt("ovl_cnt", 2);

    // Load 110; x=1 on the load cycle must be ignored, count cleared.
    step("load_z", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0);
    check_cnt("load_cnt", 0);
    stream("pat110", 1'b0, 6, 16'b110110, 16'b001001);
    check_cnt("pat110_cnt", 2);

    // en=0 gap of 4 cycles holding a would-be-matching x=1.
    step("rst3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    stream("gap_pre", 1'b0, 2, 16'b10, 16'b00);
    for (int i = 0; i < 4; i++) begin
      step("gap_en0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    end
    stream("gap_post", 1'b0, 1, 16'b1, 16'b1);

    // Reset mid-sequence abandons the partial match (x=1 would complete 101).
    stream("mid_pre", 1'b0, 2, 16'b10, 16'b00);
    step("mid_rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
    stream("mid_post", 1'b0, 3, 16'b101, 16'b001);

    // Mode switched on the match cycle itself: overlapping at bit 3 keeps
    // history, so the following 01 completes another match.
    stream("mode_sw_a", 1'b0, 2, 16'b10, 16'b00);
    stream("mode_sw_b", 1'b1, 1, 16'b1, 16'b1);
    stream("mode_sw_c", 1'b0, 2, 16'b01, 16'b01);

    // Pattern 111, overlapping, eight 1s: z on 3..8, count saturates at 3.
    step("load111", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0);
    stream("ones", 1'b1, 8, 16'b11111111, 16'b00111111);
    check_cnt("sat_cnt", 3);

    // All-zero pattern in overlapping mode.
    step("load000", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    stream("zeros", 1'b1, 5, 16'b00000, 16'b00111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_detect_param

`default_nettype wire
